l2_arbiter: RTL and testbench

- Two-port arbiter that shares the single CPU-side port of the L2 cache controller between the L1 instruction cache (read-only) and the L1 data cache (read/write).
- Latches the winning request and holds it stable on the L2 port until the L2 responds.
- Routes the response back to the winner only.
- Sits between the two L1 caches and the L2 cache.

---
 rtl/l2_arb_pkg.sv | 18 +
 rtl/l2_arb_pick.sv | 29 ++
 rtl/l2_arbiter.sv | 117 +++++++++++
 tb/tb_l2_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_arb_pkg.sv
// Types and default widths shared by the L2 arbiter and the L2 cache controller.
package l2_arb_pkg;

  localparam int unsigned L2_ADDR_W = 32;
  localparam int unsigned L2_LINE_W = 256;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SERVE_I,
    S_SERVE_D
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } requester_t;

endpackage

// File: rtl/l2_arb_pick.sv
// Combinational winner selection for the L2 arbiter.
// Build option L2_ARB_RR_EN: strict alternation instead of D priority with starvation override.
module l2_arb_pick
  import l2_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       req_i,
  input  logic       req_d,
  input  logic [2:0] starve_cnt,
  input  requester_t last_grant,
  output logic       grant_d,
  output logic       grant_valid
);

  logic unused_pick;

  assign grant_valid = req_i | req_d;

`ifdef L2_ARB_RR_EN
  // On contention, the requester that did not win last time goes next.
  assign grant_d     = req_d & (~req_i | (last_grant == REQ_I));
  assign unused_pick = ^{starve_cnt, 3'(STARVE_LIMIT)};
`else
  assign grant_d     = req_d & ~(req_i & (starve_cnt == 3'(STARVE_LIMIT)));
  assign unused_pick = (last_grant == REQ_D);
`endif

endmodule

// File: rtl/l2_arbiter.sv
// Shares the L2 CPU-side port between the L1 I-cache and L1 D-cache; holds the winning
// request until l2_resp. Build option L2_ARB_RR_EN selects round-robin arbitration.
module l2_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = L2_ADDR_W,
  parameter int unsigned LINE_W       = L2_LINE_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp
);

  localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

  arb_state_t        state_q;
  logic              l2_read_q;
  logic              l2_write_q;
  logic [ADDR_W-1:0] l2_addr_q;
  logic [LINE_W-1:0] l2_wdata_q;
  logic [2:0]        starve_cnt_q;
  requester_t        last_grant_q;

  logic req_i;
  logic req_d;
  logic grant_d;
  logic grant_valid;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

  l2_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .req_i      (req_i),
    .req_d      (req_d),
    .starve_cnt (starve_cnt_q),
    .last_grant (last_grant_q),
    .grant_d    (grant_d),
    .grant_valid(grant_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
      l2_addr_q    <= '0;
      l2_wdata_q   <= '0;
      starve_cnt_q <= '0;
      last_grant_q <= REQ_D;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (grant_valid) begin
            last_grant_q <= grant_d ? REQ_D : REQ_I;
            if (grant_d) begin
              state_q    <= S_SERVE_D;
              l2_read_q  <= d_read;
              l2_write_q <= d_write;
              l2_addr_q  <= d_addr;
              l2_wdata_q <= d_wdata;
              if (req_i && (starve_cnt_q < STARVE_MAX)) begin
                starve_cnt_q <= starve_cnt_q + 3'd1;
              end
            end else begin
              state_q      <= S_SERVE_I;
              l2_read_q    <= 1'b1;
              l2_write_q   <= 1'b0;
              l2_addr_q    <= i_addr;
              l2_wdata_q   <= '0;
              starve_cnt_q <= '0;
            end
          end
        end
        S_SERVE_I, S_SERVE_D: begin
          if (l2_resp) begin
            state_q    <= S_IDLE;
            l2_read_q  <= 1'b0;
            l2_write_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign l2_read  = l2_read_q;
  assign l2_write = l2_write_q;
  assign l2_addr  = l2_addr_q;
  assign l2_wdata = l2_wdata_q;

  // Responses are qualified combinationally so the L1 sees completion in the L2's cycle.
  assign i_resp  = l2_resp & (state_q == S_SERVE_I);
  assign d_resp  = l2_resp & (state_q == S_SERVE_D);
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

  a_d_rw_exclusive: assert property (@(posedge clk) disable iff (rst) !(d_read && d_write));

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: transaction-level model plus directed and random stimulus.
// Honours L2_ARB_RR_EN the same way the design does.
module tb_l2_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;
  localparam int unsigned STARVE = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          l2_read;
  logic          l2_write;
  logic [AW-1:0] l2_addr;
  logic [LW-1:0] l2_wdata;
  logic [LW-1:0] l2_rdata = '0;
  logic          l2_resp = 1'b0;

  l2_arbiter #(
    .ADDR_W      (AW),
    .LINE_W      (LW),
    .STARVE_LIMIT(STARVE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_read  (i_read),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_resp  (i_resp),
    .d_read  (d_read),
    .d_write (d_write),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_resp  (d_resp),
    .l2_read (l2_read),
    .l2_write(l2_write),
    .l2_addr (l2_addr),
    .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata),
    .l2_resp (l2_resp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: one outstanding transaction on the L2 port, or none.
  bit            m_busy   = 1'b0;
  bit            m_who_d  = 1'b0;
  bit            m_wr     = 1'b0;
  logic [AW-1:0] m_addr   = '0;
  logic [LW-1:0] m_wdata  = '0;
  int            m_starve = 0;
  bit            m_last_d = 1'b1;
  bit            m_i_done = 1'b0;
  bit            m_d_done = 1'b0;
  int            m_lat    = 0;
  bit            m_grants[$];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = $urandom;
    return a & ~32'h1F;
  endfunction

  task automatic check_outputs();
    chk("i_resp", i_resp, m_busy && !m_who_d && l2_resp);
    chk("d_resp", d_resp, m_busy && m_who_d && l2_resp);
    chk("l2_read", l2_read, m_busy && !m_wr);
    chk("l2_write", l2_write, m_busy && m_wr);
    if (m_busy) chk("l2_addr", l2_addr, m_addr);
    if (m_busy && m_wr) chk("l2_wdata", l2_wdata, m_wdata);
    chk("i_rdata", i_rdata, l2_rdata);
    chk("d_rdata", d_rdata, l2_rdata);
  endtask

  task automatic step_model();
    bit ri, rd, wd;
    m_i_done = 1'b0;
    m_d_done = 1'b0;
    ri = i_read;
    rd = d_read || d_write;
    if (m_busy) begin
      if (l2_resp) begin
        m_busy = 1'b0;
        if (m_who_d) m_d_done = 1'b1;
        else m_i_done = 1'b1;
      end
    end else if (ri || rd) begin
      if (ri && rd) begin
`ifdef L2_ARB_RR_EN
        wd = !m_last_d;
`else
        wd = (m_starve != STARVE);
`endif
      end else begin
        wd = rd;
      end
      if (wd) begin
        m_addr  = d_addr;
        m_wr    = d_write;
        m_wdata = d_wdata;
        if (ri && m_starve < STARVE) m_starve++;
      end else begin
        m_addr   = i_addr;
        m_wr     = 1'b0;
        m_starve = 0;
      end
      m_who_d  = wd;
      m_last_d = wd;
      m_busy   = 1'b1;
      m_lat    = $urandom_range(0, 3);
      m_grants.push_back(wd);
    end
  endtask

  // Inputs are set at the negedge; outputs are checked 1 time unit later.
  task automatic tick();
    #1;
    if (rst) begin
      m_busy   = 1'b0;
      m_starve = 0;
      m_last_d = 1'b1;
      m_i_done = 1'b0;
      m_d_done = 1'b0;
    end else begin
      check_outputs();
      step_model();
    end
    @(negedge clk);
  endtask

  task automatic drive_l2(input bit allow_stray);
    l2_rdata = rand_line();
    if (m_busy) begin
      if (m_lat == 0) l2_resp = 1'b1;
      else begin
        l2_resp = 1'b0;
        m_lat--;
      end
    end else begin
      l2_resp = allow_stray && ($urandom_range(0, 9) == 0);
    end
  endtask

  task automatic drive_l1();
    if (i_read) begin
      if (m_i_done) begin
        i_read = ($urandom_range(0, 3) == 0);
        i_addr = rand_addr();
      end
    end else if ($urandom_range(0, 2) == 0) begin
      i_read = 1'b1;
      i_addr = rand_addr();
    end
    if ((d_read || d_write) && !m_d_done) return;
    if ((d_read || d_write) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) == 0)) begin
      d_write = $urandom_range(0, 1);
      d_read  = !d_write;
      d_addr  = rand_addr();
      d_wdata = rand_line();
    end else begin
      d_read  = 1'b0;
      d_write = 1'b0;
    end
  endtask

  initial begin
    logic [LW-1:0] pat_a5, pat_w;
    bit            dut_g[$];
    bit            exp_g[10];
    bit            prev, cur;
    int            cyc;

    pat_a5 = {32{8'hA5}};
    pat_w  = {8{32'h1234_5678}};

    // Reset
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    chk("rst_l2_read", l2_read, 1'b0);
    chk("rst_l2_write", l2_write, 1'b0);
    chk("rst_l2_addr", l2_addr, '0);
    chk("rst_l2_wdata", l2_wdata, '0);
    tick();

    // I-only read
    i_read = 1'b1;
    i_addr = 32'h0000_1040;
    tick();
    chk("ionly_l2_read_c1", l2_read, 1'b1);
    chk("ionly_l2_addr_c1", l2_addr, 32'h0000_1040);
    for (int c = 1; c < 5; c++) tick();
    l2_resp  = 1'b1;
    l2_rdata = pat_a5;
    #1;
    chk("ionly_i_resp_c5", i_resp, 1'b1);
    chk("ionly_d_resp_c5", d_resp, 1'b0);
    chk("ionly_i_rdata_c5", i_rdata, pat_a5);
    tick();
    i_read  = 1'b0;
    l2_resp = 1'b0;
    chk("ionly_l2_read_c6", l2_read, 1'b0);
    tick();

    // D write; mid-transaction data change must not reach the L2
    d_write = 1'b1;
    d_addr  = 32'h0000_2000;
    d_wdata = pat_w;
    tick();
    chk("dwr_l2_write", l2_write, 1'b1);
    chk("dwr_l2_wdata", l2_wdata, pat_w);
    d_wdata = ~pat_w;
    d_addr  = 32'h0000_2FE0;
    tick();
    tick();
    chk("dwr_wdata_held", l2_wdata, pat_w);
    chk("dwr_addr_held", l2_addr, 32'h0000_2000);
    l2_resp = 1'b1;
    #1;
    chk("dwr_d_resp", d_resp, 1'b1);
    chk("dwr_i_resp", i_resp, 1'b0);
    tick();
    d_write = 1'b0;
    l2_resp = 1'b0;
    tick();

    // Contention: both requesters keep requesting continuously
`ifdef L2_ARB_RR_EN
    exp_g = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_g = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_grants.delete();
    prev = 1'b0;
    cyc  = 0;
    while (dut_g.size() < 10 && cyc < 300) begin
      i_read = 1'b1;
      i_addr = 32'h0000_3000;
      d_read = 1'b1;
      d_addr = 32'h0000_4000;
      drive_l2(1'b0);
      tick();
      cur = l2_read || l2_write;
      if (cur && !prev) dut_g.push_back(l2_addr == 32'h0000_4000);
      prev = cur;
      cyc++;
    end
    if (dut_g.size() < 10) chk("contention_grant_count", dut_g.size(), 10);
    for (int k = 0; k < 10; k++) begin
      if (k < dut_g.size()) chk($sformatf("grant_seq_%0d", k), dut_g[k], exp_g[k]);
      if (k < m_grants.size()) chk($sformatf("model_seq_%0d", k), m_grants[k], exp_g[k]);
    end
    i_read = 1'b0;
    d_read = 1'b0;
    cyc    = 0;
    while (m_busy && cyc < 20) begin
      drive_l2(1'b0);
      tick();
      cyc++;
    end
    l2_resp = 1'b0;
    tick();

    // Reset in the third S_SERVE_D cycle, then a late l2_resp
    d_write = 1'b1;
    d_addr  = 32'h0000_5000;
    d_wdata = pat_w;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    d_write = 1'b0;
    chk("midrst_l2_write", l2_write, 1'b0);
    chk("midrst_l2_read", l2_read, 1'b0);
    tick();
    l2_resp = 1'b1;
    #1;
    chk("midrst_late_d_resp", d_resp, 1'b0);
    chk("midrst_late_i_resp", i_resp, 1'b0);
    tick();
    l2_resp = 1'b0;

    // Stray l2_resp while idle
    l2_resp = 1'b1;
    #1;
    chk("stray_i_resp", i_resp, 1'b0);
    chk("stray_d_resp", d_resp, 1'b0);
    tick();
    l2_resp = 1'b0;
    chk("stray_l2_read", l2_read, 1'b0);
    chk("stray_l2_write", l2_write, 1'b0);
    tick();

    // Random traffic with occasional resets and stray responses
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst     = 1'b1;
        i_read  = 1'b0;
        d_read  = 1'b0;
        d_write = 1'b0;
        l2_resp = 1'b0;
        l2_rdata = rand_line();
      end else begin
        rst = 1'b0;
        drive_l1();
        drive_l2(1'b1);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
